clk_div_meter: RTL and testbench

- Receive-side counterpart of the 2N clock divider: measures a divided clock against the fast reference clock.
- Reports period, high time and the recovered half-ratio N, and declares lock once the ratio is stable.
- Sits beside clock-generation logic as a self-check and rate monitor, and is fed the divider output or any slow strobe clock.

---
 rtl/clk_div_meter_pkg.sv | 13 +
 rtl/clk_edge_det.sv | 43 ++++
 rtl/clk_div_meter.sv | 125 ++++++++++++
 tb/tb_clk_div_meter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_meter_pkg.sv
// Shared types and constants for the divided-clock meter.
package clk_div_meter_pkg;

  typedef enum logic [1:0] {StIdle, StFirst, StTrack, StLocked} state_e;

  localparam int unsigned DefaultLockCnt = 2;

  // Counter width able to hold the saturation value 2*max_n.
  function automatic int unsigned cnt_width(input int unsigned max_n);
    return $clog2(2 * max_n) + 1;
  endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Edge detector for a slow strobe sampled in the clk domain.
// Define CLK_DIV_METER_SYNC_EN to insert a 2-flop synchronizer ahead of the edge logic.
module clk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic s;
  logic prev_q;

`ifdef CLK_DIV_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sig};
    end
  end

  assign s = sync_q[1];
`else
  assign s = sig;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= s;
    end
  end

  always_comb begin
    rise = s & ~prev_q;
    fall = ~s & prev_q;
  end

endmodule

// File: rtl/clk_div_meter.sv
// Measures period, high time and half-ratio of a slow clock against clk, with lock and timeout.
// Define CLK_DIV_METER_SYNC_EN to synchronize clk_in before measurement.
module clk_div_meter
  import clk_div_meter_pkg::*;
#(
  parameter int unsigned MAX_N    = 256,
  parameter int unsigned CNT_W    = cnt_width(MAX_N),
  parameter int unsigned LOCK_CNT = DefaultLockCnt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] n_est,
  output logic             symmetric,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(2 * MAX_N);
  localparam logic [CNT_W-1:0] LockTarget = CNT_W'(LOCK_CNT);

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcap_q;
  logic [CNT_W-1:0] ref_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] match_inc;
  logic             sym;
  state_e           state_q;

  clk_edge_det u_edge_det (
    .clk   (clk),
    .reset (reset),
    .sig   (clk_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    sym       = (hcap_q == (cnt_q - hcap_q));
    match_inc = match_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      hcap_q     <= '0;
      ref_q      <= '0;
      match_q    <= '0;
      state_q    <= StIdle;
      period     <= '0;
      high_time  <= '0;
      n_est      <= '0;
      symmetric  <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      if (rise) begin
        cnt_q <= CNT_W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (fall) begin
        hcap_q <= cnt_q;
      end

      if (rise) begin
        // Every rise except the one leaving idle closes a full period.
        if (state_q != StIdle) begin
          period     <= cnt_q;
          high_time  <= hcap_q;
          symmetric  <= sym;
          n_est      <= sym ? (cnt_q >> 1) : '0;
          meas_valid <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            state_q <= StFirst;
          end
          StFirst: begin
            ref_q   <= cnt_q;
            match_q <= '0;
            state_q <= StTrack;
          end
          StTrack: begin
            if (cnt_q == ref_q) begin
              match_q <= match_inc;
              if (match_inc == LockTarget) begin
                state_q <= StLocked;
                locked  <= 1'b1;
              end
            end else begin
              ref_q   <= cnt_q;
              match_q <= '0;
            end
          end
          StLocked: begin
            if (cnt_q != ref_q) begin
              ref_q   <= cnt_q;
              match_q <= '0;
              locked  <= 1'b0;
              state_q <= StTrack;
            end
          end
        endcase
      end else if ((cnt_q == CntMax) && (state_q != StIdle)) begin
        // Stalled input: drop back to idle so only one pulse is issued.
        timeout <= 1'b1;
        locked  <= 1'b0;
        match_q <= '0;
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed self-checking bench for clk_div_meter (MAX_N = 8, LOCK_CNT = 2).
module tb_clk_div_meter;

  localparam int unsigned MaxN = 8;
  localparam int W = 5;
`ifdef CLK_DIV_METER_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic [W-1:0] n_est;
  logic         symmetric;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_mv = 0;
  int n_to = 0;
  int to_cyc = 0;
  int last_rise_set = 0;

  logic [W-1:0] log_per  [64];
  logic [W-1:0] log_ht   [64];
  logic [W-1:0] log_n    [64];
  logic         log_sym  [64];
  logic         log_lock [64];
  int           log_cyc  [64];

  clk_div_meter #(
    .MAX_N (MaxN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_in     (clk_in),
    .period     (period),
    .high_time  (high_time),
    .n_est      (n_est),
    .symmetric  (symmetric),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every measurement and timeout pulse as seen on the outputs.
  always @(negedge clk) begin
    if (meas_valid === 1'b1 && n_mv < 64) begin
      log_per[n_mv]  <= period;
      log_ht[n_mv]   <= high_time;
      log_n[n_mv]    <= n_est;
      log_sym[n_mv]  <= symmetric;
      log_lock[n_mv] <= locked;
      log_cyc[n_mv]  <= cyc;
      n_mv           <= n_mv + 1;
    end
    if (timeout === 1'b1) begin
      n_to   <= n_to + 1;
      to_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".period"}, 32'(period), 0);
    chk({tag, ".high_time"}, 32'(high_time), 0);
    chk({tag, ".n_est"}, 32'(n_est), 0);
    chk({tag, ".symmetric"}, 32'(symmetric), 0);
    chk({tag, ".meas_valid"}, 32'(meas_valid), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  task automatic chk_mv(input int idx, input int per, input int ht, input int n, input int sym,
                        input int lk);
    chk($sformatf("mv%0d.period", idx), 32'(log_per[idx]), per);
    chk($sformatf("mv%0d.high_time", idx), 32'(log_ht[idx]), ht);
    chk($sformatf("mv%0d.n_est", idx), 32'(log_n[idx]), n);
    chk($sformatf("mv%0d.symmetric", idx), 32'(log_sym[idx]), sym);
    chk($sformatf("mv%0d.locked", idx), 32'(log_lock[idx]), lk);
  endtask

  task automatic put(input logic v);
    clk_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      last_rise_set = cyc;
      for (int i = 0; i < h; i++) put(1'b1);
      for (int i = 0; i < l; i++) put(1'b0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // N=3, N=5, asymmetric 2/5, toggle every cycle, then stall low.
    drive(3, 3, 5);
    drive(5, 5, 4);
    drive(2, 5, 4);
    drive(1, 1, 4);
    repeat (40) put(1'b0);

    chk("mv_count_a", 32'(n_mv), 16);
    chk_mv(0, 6, 3, 3, 1, 0);
    chk("mv1.locked", 32'(log_lock[1]), 0);
    chk_mv(2, 6, 3, 3, 1, 1);
    chk_mv(4, 6, 3, 3, 1, 1);
    chk_mv(5, 10, 5, 5, 1, 0);
    chk("mv6.locked", 32'(log_lock[6]), 0);
    chk_mv(7, 10, 5, 5, 1, 1);
    chk_mv(9, 7, 2, 0, 0, 0);
    chk("mv10.locked", 32'(log_lock[10]), 0);
    chk_mv(11, 7, 2, 0, 0, 1);
    chk_mv(12, 7, 2, 0, 0, 1);
    chk_mv(13, 2, 1, 1, 1, 0);
    chk_mv(15, 2, 1, 1, 1, 1);
    chk("timeout_count", 32'(n_to), 1);
    chk("timeout_delay", 32'(to_cyc - log_cyc[15]), 16);
    chk("locked_after_timeout", 32'(locked), 0);

    // Restart from idle: first rise gives no measurement.
    drive(3, 3, 4);
    chk("mv_count_b", 32'(n_mv), 19);
    chk_mv(16, 6, 3, 3, 1, 0);
    chk("mv17.locked", 32'(log_lock[17]), 0);
    chk("mv18.locked", 32'(log_lock[18]), 1);
    chk("locked_before_reset", 32'(locked), 1);
    chk("timeout_count_b", 32'(n_to), 1);

    // Asynchronous reset while locked.
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) put(1'b0);

    drive(3, 3, 4);
    chk("mv_count_c", 32'(n_mv), 22);
    chk("mv19.locked", 32'(log_lock[19]), 0);
    chk("mv20.locked", 32'(log_lock[20]), 0);
    chk_mv(21, 6, 3, 3, 1, 1);
    chk("meas_latency", 32'(log_cyc[21] - last_rise_set), 32'(Lat));

    // Period of exactly 2*MAX_N: the rise coincides with saturation and wins.
    drive(8, 8, 2);
    repeat (4) put(1'b1);
    chk("mv_count_d", 32'(n_mv), 25);
    chk_mv(22, 6, 3, 3, 1, 1);
    chk_mv(23, 16, 8, 8, 1, 0);
    chk_mv(24, 16, 8, 8, 1, 0);
    chk("timeout_count_d", 32'(n_to), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
